// File: rtl/wormhole_output_arbiter.sv
// -----------------------------------------------------------------------------
// wormhole_output_arbiter
//
// Purpose:
//   Switch arbiter for one router output port. AGENTS_NUM input ports compete
//   for one output link. Arbitration is round-robin, with wormhole locking:
//   once a head flit wins, only that input is granted until its tail flit
//   passes. A downstream credit counter makes sure no flit is granted unless
//   the downstream buffer has a free slot.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low (rst==0 resets)
//   requests_i   bit i: input i offers a flit for this output
//   tail_i       bit i: flit offered by input i is a tail (head+tail = 1-flit)
//   credit_i     downstream freed one buffer slot this cycle
//   grants_o     one-hot or zero; bit i: the flit from input i moves this cycle
//   locked_o     port is held by a multi-flit packet (FSM is in LOCKED)
//   owner_o      index of the holding input; keeps its last value in IDLE
//   credits_o    current downstream credit count
//   overflow_o   sticky: credit_i arrived while credits were already full
//
// Handshake: requests_i[i] acts as "valid" for input i and grants_o[i] as
// its "ready". A flit transfers exactly in the cycle where both are high.
// The grant is combinational from the request, so an input may hold its
// request high across cycles and will move one flit per granted cycle.
// -----------------------------------------------------------------------------
module wormhole_output_arbiter #(
  parameter int AGENTS_NUM  = 5,
  parameter int BUFFER_SIZE = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AGENTS_NUM-1:0]            requests_i,
  input  logic [AGENTS_NUM-1:0]            tail_i,
  input  logic                             credit_i,
  output logic [AGENTS_NUM-1:0]            grants_o,
  output logic                             locked_o,
  output logic [$clog2(AGENTS_NUM)-1:0]    owner_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] credits_o,
  output logic                             overflow_o
);

  localparam int IW = $clog2(AGENTS_NUM);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(AGENTS_NUM - 1);
  localparam logic [IW:0]   NUM_W    = (IW+1)'(AGENTS_NUM);
  localparam logic [CW-1:0] FULL     = CW'(BUFFER_SIZE);

  logic [0:0]            state;
  logic [IW-1:0]         pointer;
  logic [IW-1:0]         owner;
  logic [CW-1:0]         credits;
  logic                  overflow;

  logic                  found;
  logic [IW-1:0]         winner;
  logic [IW:0]           cand;
  logic                  can_send;
  logic [AGENTS_NUM-1:0] grants;
  logic                  xfer_tail;
  logic                  transfer;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin scan starting at pointer. cand is one bit wider than an
  // index so pointer+k can be folded back into range with one subtraction.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < AGENTS_NUM; k++) begin
      cand = {1'b0, pointer} + (IW+1)'(k);
      if (cand >= NUM_W) cand = cand - NUM_W;
      if (!found && requests_i[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  // Grant selection. Reset and an empty credit count both block every grant;
  // blocked requesters simply wait, nothing else changes.
  always_comb begin
    can_send  = rst && (credits != '0);
    grants    = '0;
    xfer_tail = 1'b0;
    if (can_send) begin
      if (state == ST_IDLE) begin
        if (found) begin
          grants[winner] = 1'b1;
          xfer_tail      = tail_i[winner];
        end
      end else if (requests_i[owner]) begin
        grants[owner] = 1'b1;
        xfer_tail     = tail_i[owner];
      end
    end
    transfer = |grants;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pointer  <= '0;
      owner    <= '0;
      credits  <= FULL;
      overflow <= 1'b0;
    end else begin
      if (transfer) begin
        if (state == ST_IDLE) begin
          if (xfer_tail) begin
            // single-flit packet: port never locks, move fairness on
            pointer <= next_idx(winner);
          end else begin
            state <= ST_LOCKED;
            owner <= winner;
          end
        end else if (xfer_tail) begin
          state   <= ST_IDLE;
          pointer <= next_idx(owner);
        end
      end

      // A transfer and a returned credit in the same cycle cancel out.
      if (transfer && !credit_i) begin
        credits <= credits - 1'b1;
      end else if (credit_i && !transfer) begin
        if (credits == FULL) overflow <= 1'b1;
        else                 credits  <= credits + 1'b1;
      end
    end
  end

  assign grants_o   = grants;
  assign locked_o   = (state == ST_LOCKED);
  assign owner_o    = owner;
  assign credits_o  = credits;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wormhole_output_arbiter
//
// Bench for wormhole_output_arbiter (5 inputs, 4 credits). Inputs change 1ns
// after a rising edge; outputs are compared mid-cycle, before the next edge.
// Phases: a vector table, hand-written multi-cycle sequences, then random
// traffic compared against a small transaction-level model of the port.
// -----------------------------------------------------------------------------
module tb_wormhole_output_arbiter;

  localparam int N = 5;
  localparam int B = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] requests;
  logic [N-1:0] tails;
  logic         credit;
  logic [N-1:0] grants;
  logic         locked;
  logic [2:0]   owner;
  logic [2:0]   credits;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  wormhole_output_arbiter #(.AGENTS_NUM(N), .BUFFER_SIZE(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .requests_i (requests),
    .tail_i     (tails),
    .credit_i   (credit),
    .grants_o   (grants),
    .locked_o   (locked),
    .owner_o    (owner),
    .credits_o  (credits),
    .overflow_o (overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         cr;
    logic [N-1:0] g;
    logic         lk;
    logic [2:0]   own;
    logic [2:0]   crd;
    logic         ov;
  } vec_t;

  vec_t vecs[14];

  // scoreboard: expected grant vectors queued by the model, popped per check
  logic [N-1:0] exp_q[$];

  // reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_credits;
  bit m_ovf;

  // driver tasks
  task automatic apply(input logic r, input logic [N-1:0] req,
                       input logic [N-1:0] tl, input logic cr);
    rst      = r;
    requests = req;
    tails    = tl;
    credit   = cr;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked  = 0;
    m_owner   = 0;
    m_ptr     = 0;
    m_credits = B;
    m_ovf     = 0;
  endtask

  // Expected grant from the arbitration rules, pushed to the scoreboard.
  task automatic model_predict(input logic r, input logic [N-1:0] req);
    logic [N-1:0] g;
    g = '0;
    if (r && m_credits > 0) begin
      if (m_locked) begin
        if (req[m_owner]) g[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            g[(m_ptr + k) % N] = 1'b1;
            break;
          end
        end
      end
    end
    exp_q.push_back(g);
  endtask

  task automatic model_update(input logic r, input logic [N-1:0] tl,
                              input logic cr, input logic [N-1:0] g);
    int who;
    bit xfer;
    if (!r) begin
      model_reset();
      return;
    end
    xfer = (g != '0);
    who  = 0;
    for (int i = 0; i < N; i++) if (g[i]) who = i;
    if (xfer) begin
      if (tl[who]) begin
        m_locked = 0;
        m_ptr    = (who + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner  = who;
      end
    end
    if (xfer && !cr) m_credits--;
    else if (cr && !xfer) begin
      if (m_credits == B) m_ovf = 1;
      else                m_credits++;
    end
  endtask

  initial begin
    logic         r;
    logic [N-1:0] req;
    logic [N-1:0] tl;
    logic         cr;
    logic [N-1:0] eg;

    //            rst   req       tail      cr    g         lk    own   crd   ov
    vecs[0]  = '{1'b0, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[1]  = '{1'b0, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[2]  = '{1'b1, 5'b10101, 5'b11111, 1'b0, 5'b00001, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[3]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00100, 1'b0, 3'd0, 3'd3, 1'b0};
    vecs[4]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b10000, 1'b0, 3'd0, 3'd3, 1'b0};
    vecs[5]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00001, 1'b0, 3'd0, 3'd3, 1'b0};
    vecs[6]  = '{1'b1, 5'b10101, 5'b11111, 1'b1, 5'b00100, 1'b0, 3'd0, 3'd3, 1'b0};
    vecs[7]  = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 3'd3, 1'b0};
    vecs[8]  = '{1'b0, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[9]  = '{1'b1, 5'b01010, 5'b00000, 1'b0, 5'b00010, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[10] = '{1'b1, 5'b01010, 5'b00000, 1'b0, 5'b00010, 1'b1, 3'd1, 3'd3, 1'b0};
    vecs[11] = '{1'b1, 5'b01010, 5'b00010, 1'b0, 5'b00010, 1'b1, 3'd1, 3'd2, 1'b0};
    vecs[12] = '{1'b1, 5'b01000, 5'b01000, 1'b0, 5'b01000, 1'b0, 3'd0, 3'd1, 1'b0};
    vecs[13] = '{1'b1, 5'b01000, 5'b01000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0};

    apply(1'b0, '1, '0, 1'b0);
    tick();

    // vector table: reset, round-robin singles, wormhole lock, credit stall
    for (int v = 0; v < 14; v++) begin
      apply(vecs[v].rst, vecs[v].req, vecs[v].tail, vecs[v].cr);
      check($sformatf("tbl%0d_grants", v), 32'(grants), 32'(vecs[v].g));
      check($sformatf("tbl%0d_locked", v), 32'(locked), 32'(vecs[v].lk));
      check($sformatf("tbl%0d_credits", v), 32'(credits), 32'(vecs[v].crd));
      check($sformatf("tbl%0d_overflow", v), 32'(overflow), 32'(vecs[v].ov));
      if (vecs[v].lk) check($sformatf("tbl%0d_owner", v), 32'(owner), 32'(vecs[v].own));
      tick();
    end

    // credit stall: 6-flit packet from input 0, no credits returned
    apply(1'b0, '0, '0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 5'b00001, 5'b00000, 1'b0);
      check("stall_grant", 32'(grants), 32'h1);
      check("stall_credits", 32'(credits), 32'(4 - k));
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 5'b00001, 5'b00000, 1'b0);
      check("stall_blocked", 32'(grants), 32'h0);
      check("stall_zero", 32'(credits), 32'h0);
      check("stall_locked", 32'(locked), 32'h1);
      tick();
    end
    apply(1'b1, 5'b00001, 5'b00000, 1'b1);
    check("stall_pulse_cycle", 32'(grants), 32'h0);
    tick();
    apply(1'b1, 5'b00001, 5'b00000, 1'b0);
    check("stall_one_more", 32'(grants), 32'h1);
    check("stall_one_credit", 32'(credits), 32'h1);
    tick();
    apply(1'b1, 5'b00001, 5'b00000, 1'b0);
    check("stall_again", 32'(grants), 32'h0);
    tick();
    apply(1'b1, 5'b00001, 5'b00001, 1'b1);
    check("stall_pulse2", 32'(grants), 32'h0);
    tick();
    apply(1'b1, 5'b00001, 5'b00001, 1'b0);
    check("stall_tail", 32'(grants), 32'h1);
    check("stall_tail_locked", 32'(locked), 32'h1);
    tick();
    apply(1'b1, 5'b00000, 5'b00000, 1'b0);
    check("stall_unlocked", 32'(locked), 32'h0);
    check("stall_end_credits", 32'(credits), 32'h0);
    tick();

    // simultaneous transfer and credit, then overflow
    apply(1'b1, '0, '0, 1'b1); tick();
    apply(1'b1, '0, '0, 1'b1); tick();
    apply(1'b1, 5'b00001, 5'b00001, 1'b1);
    check("simul_grant", 32'(grants), 32'h1);
    check("simul_before", 32'(credits), 32'h2);
    tick();
    apply(1'b1, '0, '0, 1'b0);
    check("simul_after", 32'(credits), 32'h2);
    check("simul_no_ovf", 32'(overflow), 32'h0);
    tick();
    apply(1'b1, '0, '0, 1'b1); tick();
    apply(1'b1, '0, '0, 1'b1); tick();
    apply(1'b1, '0, '0, 1'b1);
    check("ovf_full", 32'(credits), 32'h4);
    check("ovf_not_yet", 32'(overflow), 32'h0);
    tick();
    apply(1'b1, '0, '0, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_saturate", 32'(credits), 32'h4);
    tick();
    apply(1'b1, 5'b00100, 5'b00100, 1'b0);
    check("ovf_rr_grant", 32'(grants), 32'h4);
    tick();
    apply(1'b1, '0, '0, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    check("ovf_credits", 32'(credits), 32'h3);
    tick();

    // reset in the middle of a packet from input 4
    apply(1'b0, '0, '0, 1'b0); tick();
    apply(1'b1, 5'b10000, 5'b00000, 1'b0);
    check("midrst_head", 32'(grants), 32'h10);
    tick();
    apply(1'b1, 5'b00001, 5'b00000, 1'b0);
    check("midrst_locked", 32'(locked), 32'h1);
    check("midrst_owner", 32'(owner), 32'h4);
    check("midrst_bubble", 32'(grants), 32'h0);
    tick();
    apply(1'b0, 5'b10001, 5'b00000, 1'b0);
    check("midrst_rst_grant", 32'(grants), 32'h0);
    tick();
    apply(1'b1, 5'b10001, 5'b00001, 1'b0);
    check("midrst_unlocked", 32'(locked), 32'h0);
    check("midrst_credits", 32'(credits), 32'h4);
    check("midrst_grant0", 32'(grants), 32'h1);
    tick();

    // random traffic against the reference model
    apply(1'b0, '0, '0, 1'b0);
    tick();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 59) != 0);
      req = N'($urandom_range(0, 31));
      tl  = N'($urandom_range(0, 31)) & N'($urandom_range(0, 31));
      cr  = ($urandom_range(0, 2) == 0);
      apply(r, req, tl, cr);
      model_predict(r, req);
      eg = exp_q.pop_front();
      check("rnd_grants", 32'(grants), 32'(eg));
      check("rnd_locked", 32'(locked), 32'(m_locked));
      check("rnd_owner", 32'(owner), 32'(m_owner));
      check("rnd_credits", 32'(credits), 32'(m_credits));
      check("rnd_overflow", 32'(overflow), 32'(m_ovf));
      model_update(r, tl, cr, eg);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
